pipe_out_buf: RTL and testbench

- Downstream consumer of the two-lane pipe datapath (cf / data_in0/1 / data_out0/1 / enable).
- Realigns the pipe's `enable` qualifier to the pipe's output latency and captures each data_out0/data_out1 pair into a small FIFO.
- Presents captured pairs to the next stage over a valid/ready handshake and tags each pair with a sequence number.
- Reports overflow when the consumer stalls longer than the FIFO can absorb.

---
 rtl/pipe_out_buf.sv | 157 +++++++++++++++
 tb/tb_pipe_out_buf.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_out_buf.sv
// pipe_out_buf: output buffer behind the two-lane pipe datapath.
//   Delays the pipe's `enable` by LAT cycles so that it lines up with
//   data_out0/1. Each aligned capture is pushed into a DEPTH-entry
//   first-word-fall-through FIFO together with an 8-bit sequence tag.
//   Captures that find the FIFO full are dropped and reported through a
//   sticky overflow flag and a saturating drop counter.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                pipe input qualifier (captured LAT cycles later)
//   data_out0/1           pipe lane results
//   out_valid/out_ready   head-entry handshake toward the next stage
//   out_data0/1, out_seq  head entry (0 while empty)
//   count                 occupancy 0..DEPTH
//   overflow, drop_cnt    sticky drop flag, saturating drop count
//   clr_ovf               synchronous clear of overflow/drop_cnt

// Per-lane storage: one write port, one asynchronous read port.
module pipe_out_buf_lane #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

module pipe_out_buf #(
  parameter int DW    = 16,
  parameter int LAT   = 3,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [DW-1:0]              data_out0,
  input  logic [DW-1:0]              data_out1,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_data0,
  output logic [DW-1:0]              out_data1,
  output logic [7:0]                 out_seq,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt,
  input  logic                       clr_ovf
);
  localparam int NUM_LANES = 2;
  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [NUM_LANES-1:0][DW-1:0] data;
    logic [7:0]                   seq;
  } entry_t;

  // enable delay line; vld_pipe[LAT] is the aligned capture strobe
  logic [LAT:1] vld_pipe;
  logic         cap;

  logic [AW-1:0] wptr, rptr;
  logic [7:0]    seq;
  logic [7:0]    seq_mem [DEPTH];
  logic          full, pop, push, drop;

  logic [NUM_LANES-1:0][DW-1:0] wr_data, rd_data;
  entry_t head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= enable;
      for (int i = 2; i <= LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign cap  = vld_pipe[LAT];
  assign full = (count == FULL_CNT);
  assign pop  = out_valid & out_ready;
  // a full FIFO still accepts a capture when the head leaves on the same edge
  assign push = cap & (~full | pop);
  assign drop = cap & ~push;

  // storage is written only on push, so X on data_out while cap=0 never lands
  assign wr_data = {data_out1, data_out0};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    pipe_out_buf_lane #(.DW(DW), .DEPTH(DEPTH)) u_lane (
      .clk  (clk),
      .we   (push),
      .waddr(wptr),
      .wdata(wr_data[l]),
      .raddr(rptr),
      .rdata(rd_data[l])
    );
  end

  always_ff @(posedge clk)
    if (push) seq_mem[wptr] <= seq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      seq   <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
        seq  <= seq + 8'd1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // a drop coinciding with clr_ovf restarts the count at 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf)                drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  // outputs depend on registered count only, never on out_ready
  assign out_valid = (count != '0);
  assign head.data = rd_data;
  assign head.seq  = seq_mem[rptr];

  // zero the head while empty so reset and idle outputs are clean
  assign out_data0 = out_valid ? head.data[0] : '0;
  assign out_data1 = out_valid ? head.data[1] : '0;
  assign out_seq   = out_valid ? head.seq     : '0;
endmodule

// File: tb/tb_pipe_out_buf.sv
// Testbench for pipe_out_buf: directed sequence with random data, checked
// every cycle against a queue-based model of the FIFO and drop counters.
module tb_pipe_out_buf;
  localparam int DW    = 16;
  localparam int LAT   = 3;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] data_out0 = '0, data_out1 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data0, out_data1;
  logic [7:0]    out_seq;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    drop_cnt;
  logic          clr_ovf = 1'b0;

  pipe_out_buf #(.DW(DW), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .data_out0(data_out0),
    .data_out1(data_out1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data0(out_data0),
    .out_data1(out_data1),
    .out_seq  (out_seq),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d0, d1;
    logic [7:0]    seq;
  } ent_t;

  // reference model state
  ent_t q[$];
  bit   en_q[$];      // enables in flight, oldest first
  int   m_seq, m_drop;
  bit   m_ovf;

  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [15:0] r16();
    return 16'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("count", 32'(count), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (q.size() != 0) begin
      chk("out_data0", 32'(out_data0), 32'(q[0].d0));
      chk("out_data1", 32'(out_data1), 32'(q[0].d1));
      chk("out_seq", 32'(out_seq), 32'(q[0].seq));
    end
  endtask

  function automatic void model_reset();
    q.delete();
    en_q.delete();
    for (int i = 0; i < LAT; i++) en_q.push_back(1'b0);
    m_seq  = 0;
    m_drop = 0;
    m_ovf  = 1'b0;
  endfunction

  // One clock: drive at negedge, update model for the coming edge, check after it.
  task automatic step(input bit en, input bit rdy, input bit clr,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    bit   cap, do_pop, do_push;
    ent_t e;
    @(negedge clk);
    enable = en; out_ready = rdy; clr_ovf = clr;
    data_out0 = d0; data_out1 = d1;
    cap = en_q.pop_front();
    en_q.push_back(en);
    do_pop  = (q.size() != 0) && rdy;
    do_push = cap && (q.size() < DEPTH || do_pop);
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      e.d0 = d0; e.d1 = d1; e.seq = 8'(m_seq);
      q.push_back(e);
      m_seq = (m_seq + 1) % 256;
    end
    if (cap && !do_push) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    @(posedge clk);
    #1;
    chk_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, r16(), r16());
  endtask

  // Reset pulse in the middle of the low phase; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    enable = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data0", 32'(out_data0), 32'd0);
    chk("rst_data1", 32'(out_data1), 32'd0);
    chk("rst_seq", 32'(out_seq), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();

    // single capture lands LAT edges after enable, then pops
    step(1'b1, 1'b0, 1'b0, r16(), r16());
    idle(LAT-1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h1234, 16'hABCD);
    chk("first_data0", 32'(out_data0), 32'h1234);
    chk("first_data1", 32'(out_data1), 32'hABCD);
    chk("first_seq", 32'(out_seq), 32'd0);
    step(1'b0, 1'b1, 1'b0, r16(), r16());
    chk("first_popped", 32'(count), 32'd0);

    // streaming with ready held: occupancy stays at most 1
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 16'(i + 16'h100), 16'(i + 16'h200));
    idle(LAT + 1, 1'b1);

    // overrun: 10 captures into 8 entries, then drain
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, r16(), r16());
    idle(LAT, 1'b0);
    chk("ovr_count", 32'(count), 32'(DEPTH));
    chk("ovr_drop", 32'(drop_cnt), 32'd2);
    idle(DEPTH + 1, 1'b1);
    step(1'b0, 1'b0, 1'b1, r16(), r16());

    // full FIFO: capture and pop on the same edge is accepted
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, r16(), r16());
    step(1'b1, 1'b0, 1'b0, r16(), r16());
    idle(LAT - 1, 1'b0);
    step(1'b0, 1'b1, 1'b0, r16(), r16());
    chk("full_pp_count", 32'(count), 32'(DEPTH));
    chk("full_pp_ovf", 32'(overflow), 32'd0);
    idle(DEPTH + 1, 1'b1);

    // five drops, then a drop coinciding with clr_ovf, then clr alone
    for (int i = 0; i < DEPTH + 6; i++) step(1'b1, 1'b0, 1'b0, r16(), r16());
    idle(LAT - 1, 1'b0);
    step(1'b0, 1'b0, 1'b1, r16(), r16());
    chk("clr_set_drop", 32'(drop_cnt), 32'd1);
    step(1'b0, 1'b0, 1'b1, r16(), r16());
    chk("clr_only_ovf", 32'(overflow), 32'd0);

    // drop counter saturation (FIFO still full)
    for (int i = 0; i < 260; i++) step(1'b1, 1'b0, 1'b0, r16(), r16());
    idle(LAT, 1'b0);
    chk("drop_sat", 32'(drop_cnt), 32'd255);
    idle(DEPTH + 1, 1'b1);
    step(1'b0, 1'b0, 1'b1, r16(), r16());

    // 300 accepted captures: seq wraps 255 -> 0
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b0, r16(), r16());
    idle(LAT + 1, 1'b1);

    // reset with 4 stored and 2 in flight: flushed, next capture seq 0
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, r16(), r16());
    idle(LAT - 2, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd4);
    do_reset();
    idle(LAT + 2, 1'b0);
    step(1'b1, 1'b0, 1'b0, r16(), r16());
    idle(LAT, 1'b0);
    chk("post_rst_seq", 32'(out_seq), 32'd0);
    idle(2, 1'b1);

    // random traffic
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
           r16(), r16());

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
